stream_frame_packetizer: RTL and testbench



---
 rtl/stream_pkt_pkg.sv | 13 +
 rtl/stream_sync_fifo.sv | 55 +++++
 rtl/stream_frame_packetizer.sv | 157 +++++++++++++++
 tb/tb_stream_frame_packetizer.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkt_pkg.sv
// Shared types and width defaults for the stream frame packetizer.
package stream_pkt_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2
    } pkt_state_t;

endpackage

// File: rtl/stream_sync_fifo.sv
// Synchronous first-word-fall-through FIFO, async active-low reset.
module stream_sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/stream_frame_packetizer.sv
// Re-frames an unframed AXI-Stream into frame_len-word frames with TLAST.
// PKT_CHECKSUM_EN: append an XOR checksum word carrying TLAST to every frame.
module stream_frame_packetizer
    import stream_pkt_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_TDATA_in,
    input  logic              s_TVALID,
    output logic              s_TREADY,
    output logic [DATA_W-1:0] m_TDATA_out,
    output logic              m_TVALID,
    input  logic              m_TREADY,
    output logic              m_TLAST,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              irq_clr,
    output logic              frame_irq,
    output logic [LEN_W-1:0]  frame_count
);

    logic              fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic [DATA_W-1:0] fifo_rd_data;

    pkt_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [LEN_W-1:0]  frame_count_q, frame_count_d;
    logic              irq_q, irq_d;
    logic              ready_en_q;
`ifdef PKT_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic              reg_free, load_word, is_last;
    logic [LEN_W-1:0]  eff_len, idx;

    // ready_en_q keeps the input closed while reset is held.
    assign s_TREADY = ready_en_q && !fifo_full;
    assign fifo_wr  = s_TVALID && s_TREADY;

    stream_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (s_TDATA_in),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        word_cnt_d    = word_cnt_q;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q;
        m_last_d      = m_last_q;
        frame_count_d = frame_count_q;
        irq_d         = irq_q;
        fifo_rd       = 1'b0;
`ifdef PKT_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        // Length is sampled only when a frame opens; zero means one word.
        reg_free  = !m_valid_q || m_TREADY;
        eff_len   = (state_q == IDLE) ? ((frame_len == '0) ? LEN_W'(1) : frame_len) : len_q;
        idx       = (state_q == IDLE) ? '0 : word_cnt_q;
        is_last   = (idx == (eff_len - LEN_W'(1)));
        load_word = reg_free && !fifo_empty && (state_q != CSUM);

        if (reg_free) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (load_word) begin
            fifo_rd    = 1'b1;
            m_data_d   = fifo_rd_data;
            m_valid_d  = 1'b1;
            len_d      = eff_len;
            word_cnt_d = idx + LEN_W'(1);
`ifdef PKT_CHECKSUM_EN
            csum_d     = ((state_q == IDLE) ? '0 : csum_q) ^ fifo_rd_data;
            m_last_d   = 1'b0;
            state_d    = is_last ? CSUM : DATA;
`else
            m_last_d   = is_last;
            state_d    = is_last ? IDLE : DATA;
`endif
        end
`ifdef PKT_CHECKSUM_EN
        else if (reg_free && (state_q == CSUM)) begin
            m_data_d  = csum_q;
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            state_d   = IDLE;
        end
`endif

        // Completion set has priority over a simultaneous clear.
        if (m_valid_q && m_TREADY && m_last_q) begin
            frame_count_d = frame_count_q + LEN_W'(1);
            irq_d         = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            word_cnt_q    <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            frame_count_q <= '0;
            irq_q         <= 1'b0;
            ready_en_q    <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            word_cnt_q    <= word_cnt_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
            frame_count_q <= frame_count_d;
            irq_q         <= irq_d;
            ready_en_q    <= 1'b1;
`ifdef PKT_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign m_TDATA_out = m_data_q;
    assign m_TVALID    = m_valid_q;
    assign m_TLAST     = m_last_q;
    assign frame_irq   = irq_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_stream_frame_packetizer.sv
// Randomized self-checking bench for stream_frame_packetizer against a frame-level model.
module tb_stream_frame_packetizer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 8;
`ifdef PKT_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_TDATA_in;
    logic          s_TVALID;
    logic          s_TREADY;
    logic [DW-1:0] m_TDATA_out;
    logic          m_TVALID;
    logic          m_TREADY;
    logic          m_TLAST;
    logic [LW-1:0] frame_len;
    logic          irq_clr;
    logic          frame_irq;
    logic [LW-1:0] frame_count;

    stream_frame_packetizer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_TDATA_in  (s_TDATA_in),
        .s_TVALID    (s_TVALID),
        .s_TREADY    (s_TREADY),
        .m_TDATA_out (m_TDATA_out),
        .m_TVALID    (m_TVALID),
        .m_TREADY    (m_TREADY),
        .m_TLAST     (m_TLAST),
        .frame_len   (frame_len),
        .irq_clr     (irq_clr),
        .frame_irq   (frame_irq),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int exp_count = 0;
    int cyc = 0;

    logic [DW-1:0] obs_data[$];
    bit            obs_last[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    int            acc_cnt, first_acc, first_val, hold_err;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records accepted beats, input handshakes and AXI hold violations.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_TVALID !== 1'b1 || m_TDATA_out !== prev_data || m_TLAST !== prev_last))
                hold_err++;
            prev_stall = m_TVALID && !m_TREADY;
            prev_data  = m_TDATA_out;
            prev_last  = m_TLAST;
            if (m_TVALID && m_TREADY) begin
                obs_data.push_back(m_TDATA_out);
                obs_last.push_back(m_TLAST);
            end
            if (s_TVALID && s_TREADY) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (m_TVALID && first_val < 0) first_val = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: split the accepted word sequence into frames of the given lengths.
    function automatic int build_exp(input logic [DW-1:0] w[$], input int lens[$]);
        int pos = 0;
        int fi = 0;
        int nfr = 0;
        int len;
        logic [DW-1:0] x;
        bit complete;
        exp_data.delete();
        exp_last.delete();
        while (pos < w.size()) begin
            len = lens[(fi < lens.size()) ? fi : lens.size() - 1];
            if (len == 0) len = 1;
            x = '0;
            complete = 1'b0;
            for (int k = 0; k < len && pos < w.size(); k++) begin
                exp_data.push_back(w[pos]);
                exp_last.push_back(!CSUM_ON && (k == len - 1));
                x ^= w[pos];
                pos++;
                if (k == len - 1) complete = 1'b1;
            end
            if (complete) begin
                if (CSUM_ON) begin
                    exp_data.push_back(x);
                    exp_last.push_back(1'b1);
                end
                nfr++;
            end
            fi++;
        end
        return nfr;
    endfunction

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        acc_cnt   = 0;
        first_acc = -1;
        first_val = -1;
        hold_err  = 0;
    endtask

    task automatic drive_words(input logic [DW-1:0] w[$], input int gap_pct, output bit to);
        bit rdy;
        int budget;
        to = 1'b0;
        foreach (w[i]) begin
            while ($urandom_range(99) < gap_pct) begin
                s_TVALID = 1'b0;
                @(posedge clk); #1;
            end
            s_TVALID   = 1'b1;
            s_TDATA_in = w[i];
            budget     = 300;
            do begin
                rdy = s_TREADY;
                @(posedge clk); #1;
                budget--;
            end while (!rdy && budget > 0);
            if (!rdy) begin
                to = 1'b1;
                s_TVALID = 1'b0;
                return;
            end
        end
        s_TVALID = 1'b0;
    endtask

    task automatic wait_beats(input int n, output bit to);
        int budget = 3000;
        while (obs_data.size() < n && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        to = (obs_data.size() < n);
    endtask

    task automatic run_stream(input logic [DW-1:0] w[$], input int gap_pct, input int rdy_pct,
                              input int nbeats, output bit to);
        bit done = 1'b0;
        bit t1, t2;
        fork
            begin
                drive_words(w, gap_pct, t1);
                wait_beats(nbeats, t2);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_TREADY = ($urandom_range(99) < rdy_pct);
                end
            end
        join
        m_TREADY = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        to = t1 | t2;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_TREADY !== 1'b0) $display("FAIL rst_s_tready got %b want 0", s_TREADY); else passed++;
        checks++; if (m_TVALID !== 1'b0) $display("FAIL rst_m_tvalid got %b want 0", m_TVALID); else passed++;
        checks++; if (m_TDATA_out !== '0) $display("FAIL rst_m_tdata got %h want 0", m_TDATA_out); else passed++;
        checks++; if (m_TLAST !== 1'b0) $display("FAIL rst_m_tlast got %b want 0", m_TLAST); else passed++;
        checks++; if (frame_irq !== 1'b0) $display("FAIL rst_irq got %b want 0", frame_irq); else passed++;
        checks++; if (frame_count !== '0) $display("FAIL rst_count got %0d want 0", frame_count); else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (s_TREADY !== 1'b1) $display("FAIL rst_release_ready got %b want 1", s_TREADY); else passed++;
        exp_count = 0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] w[$];
        int lens[$];
        int nfr;
        bit to;
        for (int i = 1; i <= 8; i++) w.push_back(DW'(i));
        lens.push_back(4);
        frame_len = LW'(4);
        m_TREADY  = 1'b1;
        nfr = build_exp(w, lens);
        clear_obs();
        run_stream(w, 0, 100, exp_data.size(), to);
        exp_count = (exp_count + nfr) % 256;
        checks++; if (to) $display("FAIL basic_timeout got timeout want done"); else passed++;
        checks++;
        if (obs_data.size() !== exp_data.size()) $display("FAIL basic_beats got %0d want %0d", obs_data.size(), exp_data.size());
        else passed++;
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
                $display("FAIL basic_beat%0d got %h last=%0b want %h last=%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            else passed++;
        end
        checks++;
        if (first_val - first_acc !== 2) $display("FAIL basic_latency got %0d want 2", first_val - first_acc);
        else passed++;
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL basic_count got %0d want %0d", frame_count, exp_count); else passed++;
        checks++; if (frame_irq !== 1'b1) $display("FAIL basic_irq got %b want 1", frame_irq); else passed++;
    endtask

`ifdef PKT_CHECKSUM_EN
    task automatic test_checksum();
        logic [DW-1:0] w[$];
        int lens[$];
        int nfr;
        bit to;
        w.push_back(32'hA5A5A5A5);
        w.push_back(32'h0F0F0F0F);
        w.push_back(32'hFFFF0000);
        lens.push_back(3);
        frame_len = LW'(3);
        nfr = build_exp(w, lens);
        clear_obs();
        run_stream(w, 20, 70, exp_data.size(), to);
        exp_count = (exp_count + nfr) % 256;
        checks++; if (to) $display("FAIL csum_timeout got timeout want done"); else passed++;
        checks++;
        if (obs_data.size() !== exp_data.size()) $display("FAIL csum_beats got %0d want %0d", obs_data.size(), exp_data.size());
        else passed++;
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
                $display("FAIL csum_beat%0d got %h last=%0b want %h last=%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            else passed++;
        end
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL csum_count got %0d want %0d", frame_count, exp_count); else passed++;
    endtask
`endif

    task automatic test_backpressure();
        logic [DW-1:0] w[$];
        int lens[$];
        int nfr;
        bit t1, t2;
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        lens.push_back(4);
        frame_len = LW'(4);
        nfr = build_exp(w, lens);
        clear_obs();
        m_TREADY = 1'b0;
        fork
            drive_words(w, 0, t1);
            begin
                repeat (10) @(posedge clk);
                #1;
                checks++; if (acc_cnt !== 5) $display("FAIL bp_accepted got %0d want 5", acc_cnt); else passed++;
                checks++; if (s_TREADY !== 1'b0) $display("FAIL bp_s_tready got %b want 0", s_TREADY); else passed++;
                checks++;
                if (m_TVALID !== 1'b1 || m_TDATA_out !== w[0])
                    $display("FAIL bp_held got %h valid=%b want %h valid=1", m_TDATA_out, m_TVALID, w[0]);
                else passed++;
                m_TREADY = 1'b1;
            end
        join
        wait_beats(exp_data.size(), t2);
        repeat (4) @(posedge clk);
        #1;
        exp_count = (exp_count + nfr) % 256;
        checks++; if (t1 | t2) $display("FAIL bp_timeout got timeout want done"); else passed++;
        checks++;
        if (obs_data.size() !== exp_data.size()) $display("FAIL bp_beats got %0d want %0d", obs_data.size(), exp_data.size());
        else passed++;
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
                $display("FAIL bp_beat%0d got %h last=%0b want %h last=%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            else passed++;
        end
        checks++; if (hold_err !== 0) $display("FAIL bp_hold got %0d violations want 0", hold_err); else passed++;
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL bp_count got %0d want %0d", frame_count, exp_count); else passed++;
    endtask

    task automatic test_len0();
        logic [DW-1:0] w[$];
        int lens[$];
        int nfr;
        bit to;
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        lens.push_back(0);
        frame_len = '0;
        nfr = build_exp(w, lens);
        clear_obs();
        run_stream(w, 10, 70, exp_data.size(), to);
        exp_count = (exp_count + nfr) % 256;
        checks++; if (to) $display("FAIL len0_timeout got timeout want done"); else passed++;
        checks++;
        if (obs_data.size() !== exp_data.size()) $display("FAIL len0_beats got %0d want %0d", obs_data.size(), exp_data.size());
        else passed++;
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
                $display("FAIL len0_beat%0d got %h last=%0b want %h last=%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            else passed++;
        end
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL len0_count got %0d want %0d", frame_count, exp_count); else passed++;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w[$];
        int lens[$];
        int nfr;
        bit to;
        lens.push_back(1);
        frame_len = LW'(1);
        for (int i = 0; i < 255 - exp_count; i++) w.push_back($urandom);
        nfr = build_exp(w, lens);
        clear_obs();
        run_stream(w, 0, 100, exp_data.size(), to);
        exp_count = (exp_count + nfr) % 256;
        checks++; if (to) $display("FAIL wrap_fill_timeout got timeout want done"); else passed++;
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL wrap_max got %0d want %0d", frame_count, exp_count); else passed++;
        w.delete();
        w.push_back($urandom);
        nfr = build_exp(w, lens);
        clear_obs();
        run_stream(w, 0, 100, exp_data.size(), to);
        exp_count = (exp_count + nfr) % 256;
        checks++; if (to) $display("FAIL wrap_timeout got timeout want done"); else passed++;
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL wrap_zero got %0d want %0d", frame_count, exp_count); else passed++;
    endtask

    task automatic test_len_change();
        logic [DW-1:0] w[$];
        int lens[$];
        int nfr;
        bit t1, t2, t3;
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        lens.push_back(3);
        lens.push_back(5);
        frame_len = LW'(3);
        m_TREADY  = 1'b1;
        nfr = build_exp(w, lens);
        clear_obs();
        fork
            drive_words(w, 0, t1);
            begin
                wait_beats(1, t3);
                frame_len = LW'(5);
            end
        join
        wait_beats(exp_data.size(), t2);
        repeat (4) @(posedge clk);
        #1;
        exp_count = (exp_count + nfr) % 256;
        checks++; if (t1 | t2 | t3) $display("FAIL lchg_timeout got timeout want done"); else passed++;
        checks++;
        if (obs_data.size() !== exp_data.size()) $display("FAIL lchg_beats got %0d want %0d", obs_data.size(), exp_data.size());
        else passed++;
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
                $display("FAIL lchg_beat%0d got %h last=%0b want %h last=%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            else passed++;
        end
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL lchg_count got %0d want %0d", frame_count, exp_count); else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [DW-1:0] w[$];
            int lens[$];
            int len, nf, nfr;
            bit to;
            len = $urandom_range(0, 6);
            nf  = $urandom_range(1, 4);
            for (int i = 0; i < nf * ((len == 0) ? 1 : len); i++) w.push_back($urandom);
            lens.push_back(len);
            frame_len = LW'(len);
            nfr = build_exp(w, lens);
            clear_obs();
            run_stream(w, 30, 60, exp_data.size(), to);
            exp_count = (exp_count + nfr) % 256;
            checks++; if (to) $display("FAIL rand%0d_timeout got timeout want done", it); else passed++;
            checks++;
            if (obs_data.size() !== exp_data.size()) $display("FAIL rand%0d_beats got %0d want %0d", it, obs_data.size(), exp_data.size());
            else passed++;
            for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
                checks++;
                if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
                    $display("FAIL rand%0d_beat%0d got %h last=%0b want %h last=%0b", it, i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
                else passed++;
            end
            checks++; if (hold_err !== 0) $display("FAIL rand%0d_hold got %0d violations want 0", it, hold_err); else passed++;
            checks++; if (frame_count !== LW'(exp_count)) $display("FAIL rand%0d_count got %0d want %0d", it, frame_count, exp_count); else passed++;
        end
    endtask

    task automatic test_irq_race();
        logic [DW-1:0] w[$];
        bit to, found;
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        @(negedge clk); #1;
        checks++; if (frame_irq !== 1'b0) $display("FAIL irq_clear got %b want 0", frame_irq); else passed++;
        frame_len = LW'(1);
        m_TREADY  = 1'b0;
        w.push_back($urandom);
        clear_obs();
        drive_words(w, 0, to);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk); #1;
            if (m_TVALID && m_TLAST) begin
                found = 1'b1;
            end else if (m_TVALID) begin
                @(posedge clk); #1 m_TREADY = 1'b1;
                @(posedge clk); #1 m_TREADY = 1'b0;
            end
        end
        checks++; if (to || !found) $display("FAIL irq_last_timeout got timeout want last beat"); else passed++;
        checks++; if (frame_irq !== 1'b0) $display("FAIL irq_pre got %b want 0", frame_irq); else passed++;
        @(posedge clk); #1;
        m_TREADY = 1'b1;
        irq_clr  = 1'b1;
        @(posedge clk); #1;
        m_TREADY = 1'b0;
        irq_clr  = 1'b0;
        exp_count = (exp_count + 1) % 256;
        @(negedge clk); #1;
        checks++; if (frame_irq !== 1'b1) $display("FAIL irq_race got %b want 1", frame_irq); else passed++;
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL irq_count got %0d want %0d", frame_count, exp_count); else passed++;
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        @(negedge clk); #1;
        checks++; if (frame_irq !== 1'b0) $display("FAIL irq_later_clear got %b want 0", frame_irq); else passed++;
        m_TREADY = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w[$];
        int lens[$];
        int nfr;
        bit to;
        frame_len = LW'(8);
        m_TREADY  = 1'b1;
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        drive_words(w, 0, to);
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (m_TVALID !== 1'b0) $display("FAIL rmid_m_tvalid got %b want 0", m_TVALID); else passed++;
        checks++; if (m_TDATA_out !== '0) $display("FAIL rmid_m_tdata got %h want 0", m_TDATA_out); else passed++;
        checks++; if (m_TLAST !== 1'b0) $display("FAIL rmid_m_tlast got %b want 0", m_TLAST); else passed++;
        checks++; if (frame_count !== '0) $display("FAIL rmid_count got %0d want 0", frame_count); else passed++;
        checks++; if (frame_irq !== 1'b0) $display("FAIL rmid_irq got %b want 0", frame_irq); else passed++;
        checks++; if (s_TREADY !== 1'b0) $display("FAIL rmid_s_tready got %b want 0", s_TREADY); else passed++;
        exp_count = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        lens.push_back(8);
        nfr = build_exp(w, lens);
        clear_obs();
        run_stream(w, 20, 80, exp_data.size(), to);
        exp_count = (exp_count + nfr) % 256;
        checks++; if (to) $display("FAIL rmid_timeout got timeout want done"); else passed++;
        checks++;
        if (obs_data.size() !== exp_data.size()) $display("FAIL rmid_beats got %0d want %0d", obs_data.size(), exp_data.size());
        else passed++;
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
                $display("FAIL rmid_beat%0d got %h last=%0b want %h last=%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            else passed++;
        end
        checks++; if (frame_count !== LW'(exp_count)) $display("FAIL rmid_count_after got %0d want %0d", frame_count, exp_count); else passed++;
    endtask

    initial begin
        s_TDATA_in = '0;
        s_TVALID   = 1'b0;
        m_TREADY   = 1'b1;
        frame_len  = LW'(4);
        irq_clr    = 1'b0;
        clear_obs();
        test_reset();
        test_basic();
`ifdef PKT_CHECKSUM_EN
        test_checksum();
`endif
        test_backpressure();
        test_len0();
        test_wrap();
        test_len_change();
        test_random();
        test_irq_race();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
